// File: rtl/hcp_tx_pkg.sv
// Shared definitions for the HCP network transmit read stage.
// Holds default timing/length constants, the descriptor field layout
// ({ts[18:0], len[10:0]}), the byte offsets that carry the ingress
// timestamp, and the read-stage state encoding.
package hcp_tx_pkg;

  localparam int IFG_CYCLES = 20;  // 8 preamble/SFD + 12 IFG
  localparam int MIN_LEN    = 60;
  localparam int LEN_W      = 11;

  // Descriptor field layout
  localparam int TS_MSB  = 29;
  localparam int TS_LSB  = 11;
  localparam int LEN_MSB = 10;
  localparam int TS_W    = TS_MSB - TS_LSB + 1;

  // Frame byte positions overwritten with the timestamp
  localparam int STAMP_B0 = 3;
  localparam int STAMP_B1 = 4;
  localparam int STAMP_B2 = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/network_tx_input_hcp.sv
// Read stage of the HCP network transmit path.
// Pops one descriptor per frame, streams the frame bytes out of a showahead
// data FIFO one per cycle, stamps the 19-bit ingress timestamp into bytes
// 3..5, zero-pads frames shorter than MIN_LEN and holds off the next frame
// for IFG_CYCLES so the downstream stage has room for preamble/SFD.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   iv_desc          showahead descriptor {ts[18:0], len[10:0]}
//   i_desc_empty     descriptor FIFO empty
//   o_desc_rd        descriptor pop (combinational, 1-cycle pulse)
//   iv_fifo_data     showahead frame byte
//   i_fifo_empty     data FIFO empty
//   o_fifo_rd        data FIFO pop (combinational)
//   ov_data          {marker, byte}; marker set on first and last byte
//   o_data_wr        ov_data valid, continuous across a frame
//   o_underrun       sticky: data FIFO was empty when a byte was required
module network_tx_input_hcp #(
  parameter int IFG_CYCLES = hcp_tx_pkg::IFG_CYCLES,
  parameter int MIN_LEN    = hcp_tx_pkg::MIN_LEN,
  parameter int LEN_W      = hcp_tx_pkg::LEN_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [29:0] iv_desc,
  input  logic        i_desc_empty,
  output logic        o_desc_rd,
  input  logic [7:0]  iv_fifo_data,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd,
  output logic [8:0]  ov_data,
  output logic        o_data_wr,
  output logic        o_underrun
);
  import hcp_tx_pkg::*;

  localparam int GAP_W = $clog2(IFG_CYCLES + 1);
  localparam logic [LEN_W-1:0] C_MIN_LEN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] C_B0      = LEN_W'(STAMP_B0);
  localparam logic [LEN_W-1:0] C_B1      = LEN_W'(STAMP_B1);
  localparam logic [LEN_W-1:0] C_B2      = LEN_W'(STAMP_B2);
  localparam logic [GAP_W-1:0] C_GAP_END = GAP_W'(IFG_CYCLES - 1);

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [TS_W-1:0]  r_ts;
  logic [GAP_W-1:0] r_gap;

  logic [LEN_W-1:0] w_desc_len;
  logic [TS_W-1:0]  w_desc_ts;
  logic [LEN_W-1:0] w_eff_len;
  logic             w_gap_ok;
  logic             w_need_rd;
  logic             w_under;
  logic             w_first;
  logic             w_last;
  logic [7:0]       w_byte;

  // Byte for the current position: FIFO data, timestamp overlay, or zero
  // for padding and for underrun (a missing FIFO byte is never stalled on).
  function automatic logic [7:0] sel_byte(
    input logic [LEN_W-1:0] cnt,
    input logic [TS_W-1:0]  ts,
    input logic [7:0]       fifo_b,
    input logic             need_rd,
    input logic             empty
  );
    logic [7:0] b;
    b = 8'h00;
    if (need_rd && !empty) begin
      if (cnt == C_B0)      b = {5'b0, ts[18:16]};
      else if (cnt == C_B1) b = ts[15:8];
      else if (cnt == C_B2) b = ts[7:0];
      else                  b = fifo_b;
    end
    return b;
  endfunction

  assign w_desc_len = iv_desc[LEN_MSB:0];
  assign w_desc_ts  = iv_desc[TS_MSB:TS_LSB];
  assign w_eff_len  = (r_len < C_MIN_LEN) ? C_MIN_LEN : r_len;
  assign w_gap_ok   = (r_gap >= C_GAP_END);

  assign o_desc_rd  = (r_state == ST_IDLE) && !i_desc_empty && w_gap_ok;
  assign w_need_rd  = (r_state == ST_SEND) && (r_cnt < r_len);
  assign o_fifo_rd  = w_need_rd && !i_fifo_empty;
  assign w_under    = w_need_rd && i_fifo_empty;
  assign w_first    = (r_cnt == '0);
  assign w_last     = (r_cnt == w_eff_len - LEN_W'(1));
  assign w_byte     = sel_byte(r_cnt, r_ts, iv_fifo_data, w_need_rd, i_fifo_empty);

  // Control FSM with registered output stage; the byte selected in SEND
  // appears on ov_data one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_GAP;
      r_gap      <= GAP_W'(IFG_CYCLES);
      r_len      <= '0;
      r_cnt      <= '0;
      r_ts       <= '0;
      ov_data    <= '0;
      o_data_wr  <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_data_wr <= 1'b0;
          // A zero-length descriptor is dropped without leaving IDLE.
          if (o_desc_rd && (w_desc_len != '0)) begin
            r_len   <= w_desc_len;
            r_ts    <= w_desc_ts;
            r_cnt   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          o_data_wr <= 1'b1;
          ov_data   <= {(w_first || w_last), w_byte};
          if (w_under) o_underrun <= 1'b1;
          if (w_last) begin
            r_gap   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + LEN_W'(1);
          end
        end
        ST_GAP: begin
          o_data_wr <= 1'b0;
          if (w_gap_ok) r_state <= ST_IDLE;
          else          r_gap   <= r_gap + GAP_W'(1);
        end
        default: begin
          o_data_wr <= 1'b0;
          r_state   <= ST_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_network_tx_input_hcp.sv
// Directed self-checking bench for network_tx_input_hcp.
// Models the showahead descriptor and data FIFOs, captures every written
// output word with its cycle number, and compares frames against
// hand-derived expectations.
module tb_network_tx_input_hcp;

  logic        i_clk;
  logic        i_rst_n;
  logic [29:0] iv_desc;
  logic        i_desc_empty;
  logic        o_desc_rd;
  logic [7:0]  iv_fifo_data;
  logic        i_fifo_empty;
  logic        o_fifo_rd;
  logic [8:0]  ov_data;
  logic        o_data_wr;
  logic        o_underrun;

  network_tx_input_hcp dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .iv_desc      (iv_desc),
    .i_desc_empty (i_desc_empty),
    .o_desc_rd    (o_desc_rd),
    .iv_fifo_data (iv_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rd    (o_fifo_rd),
    .ov_data      (ov_data),
    .o_data_wr    (o_data_wr),
    .o_underrun   (o_underrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // FIFO models: writes from the stimulus process, reads on DUT pops
  logic [29:0] desc_mem [0:15];
  logic [7:0]  data_mem [0:255];
  int dwr = 0, drd = 0, fwr = 0, frd = 0;
  int desc_pops = 0, fifo_pops = 0;

  assign i_desc_empty = (drd == dwr);
  assign iv_desc      = desc_mem[drd & 15];
  assign i_fifo_empty = (frd == fwr);
  assign iv_fifo_data = data_mem[frd & 255];

  always @(posedge i_clk) begin
    if (o_desc_rd) begin
      drd       <= drd + 1;
      desc_pops <= desc_pops + 1;
    end
    if (o_fifo_rd) begin
      frd       <= frd + 1;
      fifo_pops <= fifo_pops + 1;
    end
  end

  // Output capture
  logic [8:0] cap     [0:1023];
  int         cap_cyc [0:1023];
  int ncap = 0, cyc = 0;

  always @(negedge i_clk) begin
    cyc <= cyc + 1;
    if (o_data_wr) begin
      cap[ncap]     <= ov_data;
      cap_cyc[ncap] <= cyc;
      ncap          <= ncap + 1;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bytes(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      data_mem[fwr & 255] = 8'((start + i) & 255);
      fwr = fwr + 1;
    end
  endtask

  task automatic push_desc(input logic [18:0] ts, input logic [10:0] len);
    desc_mem[dwr & 15] = {ts, len};
    dwr = dwr + 1;
  endtask

  // Wait (bounded) for the capture count to reach target, then confirm
  // no further writes follow.
  task automatic wait_caps(input string tag, input int target);
    int t;
    t = 0;
    while (ncap < target && t < 2000) begin
      @(negedge i_clk);
      t++;
    end
    repeat (30) @(negedge i_clk);
    chk(tag, ncap, target);
  endtask

  // Expected byte i of a frame: FIFO source byte (src+i) for i<avail,
  // zero beyond; timestamp at bytes 3..5; marker on first and last.
  task automatic check_frame(input string tag, input int base, input int len,
                             input logic [18:0] ts, input int src, input int avail);
    int eff, e;
    eff = (len < 60) ? 60 : len;
    for (int i = 0; i < eff; i++) begin
      if (i < len && i < avail) e = (src + i) & 255;
      else                      e = 0;
      if (i == 3) e = {5'b0, ts[18:16]};
      if (i == 4) e = ts[15:8];
      if (i == 5) e = ts[7:0];
      if (i == 0 || i == eff - 1) e = e | 9'h100;
      chk($sformatf("%s byte%0d", tag, i), int'(cap[base + i]), e);
    end
    chk({tag, " contiguous"}, cap_cyc[base + eff - 1] - cap_cyc[base], eff - 1);
  endtask

  int base, dp0, fp0, t;

  initial begin
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst ov_data", int'(ov_data), 0);
    chk("rst o_data_wr", int'(o_data_wr), 0);
    chk("rst o_desc_rd", int'(o_desc_rd), 0);
    chk("rst o_fifo_rd", int'(o_fifo_rd), 0);
    chk("rst o_underrun", int'(o_underrun), 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // 1: 64-byte frame, timestamp stamping
    base = ncap; dp0 = desc_pops; fp0 = fifo_pops;
    push_bytes(8'h00, 64);
    push_desc(19'h5A5A5, 11'd64);
    wait_caps("t1 writes", base + 64);
    check_frame("t1", base, 64, 19'h5A5A5, 8'h00, 64);
    chk("t1 stamp b3", int'(cap[base + 3]), 9'h005);
    chk("t1 stamp b4", int'(cap[base + 4]), 9'h0A5);
    chk("t1 stamp b5", int'(cap[base + 5]), 9'h0A5);
    chk("t1 fifo pops", fifo_pops - fp0, 64);
    chk("t1 desc pops", desc_pops - dp0, 1);

    // 2: short frame padded to 60
    base = ncap; fp0 = fifo_pops;
    push_bytes(8'h40, 42);
    push_desc(19'h12345, 11'd42);
    wait_caps("t2 writes", base + 60);
    check_frame("t2", base, 42, 19'h12345, 8'h40, 42);
    chk("t2 last marker", int'(cap[base + 59]), 9'h100);
    chk("t2 fifo pops", fifo_pops - fp0, 42);

    // 3: back-to-back frames, inter-frame spacing
    base = ncap;
    push_bytes(8'h00, 64);
    push_bytes(8'h80, 64);
    push_desc(19'h00001, 11'd64);
    push_desc(19'h7FFFF, 11'd64);
    wait_caps("t3 writes", base + 128);
    check_frame("t3a", base, 64, 19'h00001, 8'h00, 64);
    check_frame("t3b", base + 64, 64, 19'h7FFFF, 8'h80, 64);
    chk("t3 idle gap", cap_cyc[base + 64] - cap_cyc[base + 63] - 1, 21);

    // 4: zero-length descriptor dropped
    base = ncap; dp0 = desc_pops; fp0 = fifo_pops;
    push_bytes(8'hC0, 64);
    push_desc(19'h11111, 11'd0);
    push_desc(19'h2468A, 11'd64);
    wait_caps("t4 writes", base + 64);
    check_frame("t4", base, 64, 19'h2468A, 8'hC0, 64);
    chk("t4 desc pops", desc_pops - dp0, 2);
    chk("t4 fifo pops", fifo_pops - fp0, 64);
    chk("t4 no underrun", int'(o_underrun), 0);

    // 5: underrun, only 10 bytes available
    base = ncap; fp0 = fifo_pops;
    push_bytes(8'h10, 10);
    push_desc(19'h0ABCD, 11'd64);
    wait_caps("t5 writes", base + 64);
    check_frame("t5", base, 64, 19'h0ABCD, 8'h10, 10);
    chk("t5 fifo pops", fifo_pops - fp0, 10);
    chk("t5 underrun", int'(o_underrun), 1);
    repeat (10) @(negedge i_clk);
    chk("t5 underrun held", int'(o_underrun), 1);

    // 6: asynchronous reset mid-frame
    base = ncap;
    push_bytes(8'h00, 64);
    push_desc(19'h33333, 11'd64);
    t = 0;
    while (ncap < base + 31 && t < 2000) begin
      @(negedge i_clk);
      t++;
    end
    chk("t6 reached byte30", int'(ncap >= base + 31), 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6 rst ov_data", int'(ov_data), 0);
    chk("t6 rst o_data_wr", int'(o_data_wr), 0);
    chk("t6 rst o_fifo_rd", int'(o_fifo_rd), 0);
    chk("t6 rst o_desc_rd", int'(o_desc_rd), 0);
    chk("t6 rst o_underrun", int'(o_underrun), 0);
    @(negedge i_clk);
    fwr = frd;  // external FIFO flushed by its owner
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    base = ncap;
    push_bytes(8'h20, 60);
    push_desc(19'h4C3B2, 11'd60);
    wait_caps("t6 writes", base + 60);
    check_frame("t6", base, 60, 19'h4C3B2, 8'h20, 60);
    chk("t6 first marker", int'(cap[base][8]), 1);
    chk("t6 no underrun", int'(o_underrun), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/network_tx_input_hcp.md
Name: network_tx_input_hcp

Overview:
Read stage of the HCP network transmit path. It pulls complete frames from a byte-wide data FIFO, with one descriptor FIFO entry per frame, and emits them as a continuous 9-bit stream (bit 8 marks the first and last byte) to the preamble/PTP-TC insertion stage. Along the way it:
- stamps the frame's 19-bit ingress timestamp into bytes 3..5;
- pads short frames;
- enforces the inter-frame spacing the downstream stage needs to emit preamble/SFD.

Parameters:
IFG_CYCLES, 20, minimum idle cycles between last byte of a frame and first byte of the next (8 preamble/SFD + 12 IFG)
MIN_LEN, 60, frames shorter than this are zero-padded to this length
LEN_W, 11, width of descriptor length field

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous, active-low reset
iv_desc  in  30  showahead descriptor {ts[18:0], len[10:0]}; valid when i_desc_empty=0
i_desc_empty  in  1  descriptor FIFO empty
o_desc_rd  out  1  descriptor pop, 1-cycle pulse
iv_fifo_data  in  8  showahead frame byte
i_fifo_empty  in  1  data FIFO empty
o_fifo_rd  out  1  data FIFO pop
ov_data  out  9  {marker, byte}; marker=1 on first and last byte
o_data_wr  out  1  ov_data valid
o_underrun  out  1  sticky; set when the data FIFO was empty during a required read

Behaviour:
- Reset values: ov_data=0, o_data_wr=0, o_desc_rd=0, o_fifo_rd=0, o_underrun=0, state=GAP, gap counter=IFG_CYCLES (ready immediately after reset). Reset mid-frame abandons the frame; FIFO contents are not flushed by this block.
- Writer contract: all bytes of a frame are written before its descriptor, so the data FIFO never runs empty mid-frame in normal operation.
- IDLE:
  - If !i_desc_empty and gap satisfied: o_desc_rd=1 (combinational, same cycle); latch ts and len; set byte counter cnt=0; go to SEND.
  - If len==0: pop the descriptor, emit nothing, stay in IDLE.
  - eff_len = max(len, MIN_LEN).
- SEND, one byte per cycle, no stalls:
  - While cnt<len: o_fifo_rd=1 and the byte is taken from iv_fifo_data. Bytes cnt=3,4,5 are replaced by {5'b0,ts[18:16]}, ts[15:8], ts[7:0]; the FIFO byte is still consumed.
  - While len<=cnt<eff_len: output byte 0x00, o_fifo_rd=0.
  - ov_data/o_data_wr are registered, so the first byte appears 2 cycles after the o_desc_rd cycle.
  - Marker=1 at cnt==0 and at cnt==eff_len-1.
  - After the last byte: go to GAP and clear the gap counter.
- Underrun: if o_fifo_rd is required and i_fifo_empty=1, output 0x00 and set o_underrun. Continue the frame without stalling (o_data_wr stays 1) and do not pop.
- GAP: counter increments each cycle with o_data_wr=0; go to IDLE when counter ≥ IFG_CYCLES-1. A descriptor is then accepted in IDLE, so the first byte of the next frame appears at least IFG_CYCLES+1 idle cycles after the previous last byte.
- o_data_wr is continuous (all 1s) from first to last byte of a frame.
- Counters: cnt is LEN_W bits. len>2047 cannot occur; len up to 2047 is sent as-is.

Decomposition:
- Shared package hcp_tx_pkg: IFG_CYCLES, MIN_LEN, descriptor field offsets (TS_MSB=29, TS_LSB=11, LEN_MSB=10), stamp byte offsets (3,4,5), state encoding {IDLE, SEND, GAP}.
- Single module; the no-sub-module structure is natural. Optional sub-module hcp_gap_counter only if reused elsewhere.

Test Plan:
1. Desc {ts=19'h5A5A5, len=64}, bytes 0x00..0x3F → 64 writes. ov_data[8]=1 on bytes 0 and 63. Bytes 3/4/5 = 0x05/0xA5/0xA5; others equal the FIFO bytes. Exactly 64 FIFO pops, 1 descriptor pop.
2. Desc len=42 → 60 writes: bytes 42..59 = 0x00, marker on byte 59, only 42 FIFO pops.
3. Two back-to-back 64-byte descriptors → exactly 21 cycles with o_data_wr=0 between the two last/first bytes; the second frame's first byte marker=1.
4. Descriptor with len=0 followed by len=64 → first descriptor popped with no output; the second frame is sent normally.
5. len=64 descriptor but only 10 bytes in FIFO → 64 writes, bytes 10..63 = 0x00, o_underrun=1 and held until reset.
6. Assert i_rst_n=0 at byte 30 → outputs return to reset values asynchronously. After release, the next descriptor is sent starting with a marker byte.
